// File: rtl/core_pkg.sv
// Shared types and constants for the MEM/WB writeback slice of the 64-bit core.
package core_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_HOLD  = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    // Access size in bytes; the reserved encoding behaves as a doubleword.
    function automatic logic [3:0] load_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: load_bytes = 4'd1;
            F3_LH, F3_LHU: load_bytes = 4'd2;
            F3_LW, F3_LWU: load_bytes = 4'd4;
            default:       load_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// Memory-stage to writeback handshake bundle (done/valid plus the result payload).
interface mem_wb_writeback_if;
    import core_pkg::*;

    logic                  memory_done;
    logic [XLEN-1:0]       loaded_data;
    logic [XLEN-1:0]       alu_data;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [1:0]            wb_sel;
    logic [2:0]            load_funct3;
    logic                  mem_wb_pipeline_valid;

    modport master (
        output memory_done, loaded_data, alu_data, pc_plus4, rd, reg_write, wb_sel, load_funct3,
        input  mem_wb_pipeline_valid
    );

    modport slave (
        input  memory_done, loaded_data, alu_data, pc_plus4, rd, reg_write, wb_sel, load_funct3,
        output mem_wb_pipeline_valid
    );

endinterface

// File: rtl/mem_wb_writeback_load_extender.sv
// Extracts a B/H/W/D field from a cache doubleword at a byte offset and sign/zero-extends it.
module load_extender
    import core_pkg::*;
(
    input  logic [XLEN-1:0] loaded_data,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value,
    output logic            misalign
);

    logic [XLEN-1:0] shifted_s;

    // Zero-filled shift makes bytes beyond the doubleword read as 0 before extension.
    always_comb begin
        shifted_s = loaded_data >> {off, 3'b000};
        case (funct3)
            F3_LB:   value = {{(XLEN-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_LH:   value = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_LW:   value = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_LBU:  value = {{(XLEN-8){1'b0}},           shifted_s[7:0]};
            F3_LHU:  value = {{(XLEN-16){1'b0}},          shifted_s[15:0]};
            F3_LWU:  value = {{(XLEN-32){1'b0}},          shifted_s[31:0]};
            default: value = shifted_s;
        endcase
    end

    assign misalign = ({1'b0, off} + load_bytes(funct3)) > 4'd8;

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file writeback; one write per memory_done assertion.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module mem_wb_writeback
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mem_wb_writeback_if.slave     mem,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_data,
    output logic                  misalign_error,
    output logic [63:0]           retired_count
);

    localparam logic [1:0] ST_IDLE  = WB_IDLE;
    localparam logic [1:0] ST_WRITE = WB_WRITE;
    localparam logic [1:0] ST_HOLD  = WB_HOLD;

    logic [1:0]            state_r;
    logic [XLEN-1:0]       alu_r;
    logic [XLEN-1:0]       loaded_r;
    logic [XLEN-1:0]       pc4_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic                  reg_write_r;
    logic [1:0]            wb_sel_r;
    logic [2:0]            funct3_r;
    logic [XLEN-1:0]       ext_s;
    logic                  ext_misalign_s;
    logic                  write_s;

    load_extender u_load_extender (
        .loaded_data (loaded_r),
        .off         (alu_r[2:0]),
        .funct3      (funct3_r),
        .value       (ext_s),
        .misalign    (ext_misalign_s)
    );

    // Handshake FSM and MEM/WB latch; the latch only loads on the IDLE capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            alu_r       <= '0;
            loaded_r    <= '0;
            pc4_r       <= '0;
            rd_r        <= '0;
            reg_write_r <= 1'b0;
            wb_sel_r    <= 2'd0;
            funct3_r    <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem.memory_done) begin
                        alu_r       <= mem.alu_data;
                        loaded_r    <= mem.loaded_data;
                        pc4_r       <= mem.pc_plus4;
                        rd_r        <= mem.rd;
                        reg_write_r <= mem.reg_write;
                        wb_sel_r    <= mem.wb_sel;
                        funct3_r    <= mem.load_funct3;
                        state_r     <= ST_WRITE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_WRITE: state_r <= ST_HOLD;
                ST_HOLD: begin
                    if (mem.memory_done) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from the latch; reset masks them so nothing is written in the reset cycle.
    always_comb begin
        write_s                   = (state_r == ST_WRITE) && !reset;
        mem.mem_wb_pipeline_valid = (state_r != ST_IDLE) && !reset;
        rf_write_en               = write_s && reg_write_r && (rd_r != '0);
        if (write_s) begin
            rf_write_addr  = rd_r;
            misalign_error = (wb_sel_r == WB_MEM) && ext_misalign_s;
            case (wb_sel_r)
                WB_MEM:  rf_write_data = ext_s;
                WB_PC4:  rf_write_data = pc4_r;
                default: rf_write_data = alu_r;
            endcase
        end else begin
            rf_write_addr  = '0;
            misalign_error = 1'b0;
            rf_write_data  = '0;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retired_r;

    // Counts every WRITE cycle, including writes suppressed by rd=0 or reg_write=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= 64'd0;
        end else if (state_r == ST_WRITE) begin
            retired_r <= retired_r + 64'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired_count = retired_r;
`else
    assign retired_count = 64'd0;
`endif

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- Downstream neighbour of the memory stage in the 64-bit pipelined core; owns the MEM/WB pipeline register and the writeback step.
- Captures the memory stage's result when memory_done asserts.
- Extracts and extends load data from the 64-bit doubleword returned by the data cache, selects the writeback source and drives the register-file write port for exactly one cycle.
- Returns mem_wb_pipeline_valid to the memory stage to close the done/valid handshake.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- memory_done  input  1  memory stage result ready
- loaded_data  input  XLEN  doubleword containing the load address, as returned by the data cache
- alu_data  input  XLEN  ALU result; also the load address
- pc_plus4  input  XLEN  link value for JAL/JALR
- rd  input  REG_ADDR_W  destination register
- reg_write  input  1  instruction writes rd
- wb_sel  input  2  0=ALU, 1=MEM, 2=PC+4, 3=reserved (treated as ALU)
- load_funct3  input  3  0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 7 reserved (treated as LD)
- mem_wb_pipeline_valid  output  1  latch holds a captured instruction
- rf_write_en  output  1  register-file write strobe
- rf_write_addr  output  REG_ADDR_W  write address
- rf_write_data  output  XLEN  write data
- misalign_error  output  1  one-cycle pulse: load crossed a doubleword boundary
- retired_count  output  64  retired-instruction count (optional feature)

Behaviour:
- FSM states: IDLE, WRITE, HOLD. Reset → IDLE.
- Reset values: all outputs 0; all latch registers 0.
- IDLE: valid=0. If memory_done=1, latch alu_data, loaded_data, pc_plus4, rd, reg_write, wb_sel and load_funct3, then go to WRITE.
- WRITE (exactly 1 cycle):
  - valid=1.
  - rf_write_en = latched reg_write AND latched rd≠0.
  - rf_write_addr = latched rd; rf_write_data is the selected value, driven combinationally from the latch.
  - Next state is HOLD.
- HOLD: valid=1, rf_write_en=0. Stay while memory_done=1; go to IDLE the first cycle memory_done=0.
- Result: one write per memory_done assertion, however long memory_done stays high.
- Latency: memory_done high in cycle N → capture at end of N → write strobe in N+1 → register file updated at end of N+1.
- Memory stage drops memory_done on seeing valid, giving a minimum cadence of 3 cycles per instruction.
- Inputs are ignored in WRITE and HOLD; the latch changes only on the IDLE capture.
- Load extraction, using latched values:
  - off = alu_data[2:0]; shifted = loaded_data >> (8*off), zero-filled.
  - Widths: B=8, H=16, W=32, D=64 bits taken from shifted[width-1:0].
  - Signed forms (0/1/2) replicate the top bit of the field; unsigned forms (4/5/6) zero-fill.
- Misalignment:
  - Condition: off + bytes > 8, with bytes = 1/2/4/8.
  - Bytes past the doubleword read as 0 before extension.
  - misalign_error pulses during WRITE only when wb_sel=MEM; the write still occurs.
- wb_sel=ALU or PC+4: the latched value is passed unchanged.
- Reset mid-operation (WRITE or HOLD): immediate return to IDLE with outputs zeroed; no write occurs in the reset cycle.
- After reset, a memory_done that is still high is captured as a new instruction.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined: 64-bit counter, reset 0, increments in every WRITE cycle (including rd=0 and reg_write=0); wraps from 2^64−1 to 0.
- Undefined: retired_count tied to 0, no counter logic.

Decomposition:
- Shared package (core_pkg):
  - wb_sel_e enum (WB_ALU, WB_MEM, WB_PC4).
  - load_funct3 localparams.
  - wb_state_e enum.
  - XLEN constant.
- Sub-module load_extender: combinational; inputs loaded_data, off, funct3; outputs value and misalign. Instantiated once.

Test Plan:
- LB: loaded_data=0x88776655_F4332211, alu_data=0x1003, funct3=0, rd=5, wb_sel=MEM → single WRITE cycle, rf_write_data=0xFFFFFFFF_FFFFFFF4, addr 5.
- Same stimulus, funct3=4 (LBU) → 0xF4. LW at alu_data=0x1004 → 0xFFFFFFFF_88776655. LWU → 0x00000000_88776655.
- ALU op, rd=0, reg_write=1, alu_data=0x1234 → rf_write_en stays 0, valid pulses. With the macro defined, retired_count increments by 1.
- memory_done held high 5 cycles → exactly one rf_write_en pulse. valid stays 1 until the cycle after memory_done falls, then returns to IDLE.
- LH at alu_data=0x2007, loaded_data[63:56]=0x80 → misalign_error pulse, rf_write_data=0x00000000_00000080.
- Reset asserted during HOLD → next cycle valid=0, rf_write_en=0. A later memory_done is captured normally; wb_sel=PC4 with pc_plus4=0x4008 writes 0x4008.
